mult_wb_buffer: RTL and testbench

Result buffer between the mult functional unit and the shared writeback port.
- The multiplier inside mult is fixed-latency and cannot be stalled, so this block absorbs its results in a small FIFO.
- It drains the FIFO to writeback under a valid/ready handshake.
- It issues credits to the issue stage so the FIFO can never overflow.
- It discards stale multiplier results still in the pipe after a flush.

---
 rtl/mult_wb_buffer_pkg.sv | 13 +
 rtl/mult_wb_buffer_fifo.sv | 74 +++++++
 rtl/mult_wb_buffer.sv | 103 ++++++++++
 tb/tb_mult_wb_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_wb_buffer_pkg.sv
// Shared types and constants for the mult writeback buffer slice.
// MULT_LAT must track the multiplier pipeline depth.
package mult_wb_buffer_pkg;

  localparam int TRANS_ID_BITS = 3;
  localparam int MULT_LAT      = 2;

  typedef struct packed {
    logic [63:0]              result;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } wb_entry_t;

endpackage

// File: rtl/mult_wb_buffer_fifo.sv
// Small synchronous FIFO of writeback entries with a flush that empties it in one cycle.
// Simultaneous push and pop are accepted even when full.
module mult_wb_buffer_fifo
  import mult_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  wb_entry_t                  data_i,
  input  logic                       pop_i,
  output wb_entry_t                  data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != FULL_CNT) || pop_ok);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are power-of-two wide, so the increment wraps naturally.
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mult_wb_buffer.sv
// Absorbs non-stallable multiplier results, drains them to writeback, and hands out
// issue credits so the FIFO cannot overflow. Stale results after a flush are dropped.
module mult_wb_buffer
  import mult_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_mul_i,
  input  logic                     issue_div_i,
  output logic                     issue_ready_o,
  input  logic                     in_valid_i,
  input  logic [63:0]              in_result_i,
  input  logic [TRANS_ID_BITS-1:0] in_trans_id_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              out_result_o,
  output logic [TRANS_ID_BITS-1:0] out_trans_id_o
);

  logic [MULT_LAT-1:0]    mul_pipe_q, mul_pipe_d;
  logic [MULT_LAT-1:0]    discard_q, discard_d;
  logic                   div_pending_q, div_pending_d;
  logic                   mul_tail, discard_tail;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  wb_entry_t              push_entry, head_entry;
  int                     in_flight;

  assign mul_tail     = mul_pipe_q[MULT_LAT-1];
  assign discard_tail = discard_q[MULT_LAT-1];

  always_comb begin
    mul_pipe_d    = mul_pipe_q << 1;
    mul_pipe_d[0] = issue_mul_i && !flush_i;
    discard_d     = discard_q << 1;
    div_pending_d = div_pending_q;
    // Mul has output priority, so a live arrival with no mul due is the divider.
    if (in_valid_i && !mul_tail && !discard_tail) div_pending_d = 1'b0;
    if (issue_div_i) div_pending_d = 1'b1;
    if (flush_i) begin
      discard_d     = mul_pipe_q << 1;
      discard_d[0]  = issue_mul_i;
      mul_pipe_d    = '0;
      div_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mul_pipe_q    <= '0;
      discard_q     <= '0;
      div_pending_q <= 1'b0;
    end else begin
      mul_pipe_q    <= mul_pipe_d;
      discard_q     <= discard_d;
      div_pending_q <= div_pending_d;
    end
  end

  // Credits count everything that may still land in the FIFO; registered state only.
  always_comb begin
    in_flight     = int'(fifo_count) + $countones(mul_pipe_q) + int'(div_pending_q);
    issue_ready_o = (in_flight < DEPTH);
  end

  assign push                = in_valid_i && !discard_tail && !flush_i;
  assign pop                 = out_valid_o && out_ready_i;
  assign push_entry.result   = in_result_i;
  assign push_entry.trans_id = in_trans_id_i;

  mult_wb_buffer_fifo #(
    .DEPTH (DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid_o    = !fifo_empty;
  assign out_result_o   = head_entry.result;
  assign out_trans_id_o = head_entry.trans_id;

  a_issue_with_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((issue_mul_i || issue_div_i) && !flush_i) |-> issue_ready_o);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && fifo_full && !pop));

  a_arrival_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (in_valid_i && !flush_i) |-> (mul_tail || div_pending_q || discard_tail));

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Randomized bench for mult_wb_buffer: acts as the mult unit and compares the DUT
// against a queue-based model of in-flight ops and buffered results.
module tb_mult_wb_buffer;
  import mult_wb_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic                     issue_mul_i;
  logic                     issue_div_i;
  logic                     issue_ready_o;
  logic                     in_valid_i;
  logic [63:0]              in_result_i;
  logic [TRANS_ID_BITS-1:0] in_trans_id_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [63:0]              out_result_o;
  logic [TRANS_ID_BITS-1:0] out_trans_id_o;

  always #5 clk_i = ~clk_i;

  mult_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .issue_mul_i    (issue_mul_i),
    .issue_div_i    (issue_div_i),
    .issue_ready_o  (issue_ready_o),
    .in_valid_i     (in_valid_i),
    .in_result_i    (in_result_i),
    .in_trans_id_i  (in_trans_id_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_result_o   (out_result_o),
    .out_trans_id_o (out_trans_id_o)
  );

  typedef struct {
    int                       due;
    bit                       stale;
    logic [63:0]              res;
    logic [TRANS_ID_BITS-1:0] id;
  } mul_op_t;

  mul_op_t                  mq[$];
  wb_entry_t                exp_q[$];
  bit                       div_active;
  int                       div_cnt;
  logic [63:0]              div_res;
  logic [TRANS_ID_BITS-1:0] div_id;
  int                       cyc;
  int                       n_checks;
  int                       n_fail;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int modelCredit();
    int c;
    c = exp_q.size() + int'(div_active);
    foreach (mq[i]) if (!mq[i].stale) c++;
    return c;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic applyStimulus(input bit fl, input bit rdy, input bit imul, input bit idiv,
                               input logic [63:0] res, input logic [TRANS_ID_BITS-1:0] id);
    bit        arr_mul, arr_div, arr_stale, pop;
    wb_entry_t arr_e;

    checkOutput("issue_ready", 64'(issue_ready_o), 64'(modelCredit() < DEPTH));
    checkOutput("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      checkOutput("out_result", out_result_o, exp_q[0].result);
      checkOutput("out_trans_id", 64'(out_trans_id_o), 64'(exp_q[0].trans_id));
    end

    if (fl || !issue_ready_o || modelCredit() >= DEPTH) begin
      imul = 1'b0;
      idiv = 1'b0;
    end
    if (div_active) idiv = 1'b0;
    if (idiv) imul = 1'b0;

    arr_mul   = (mq.size() != 0) && (mq[0].due == cyc);
    arr_div   = !arr_mul && div_active && (div_cnt == 0);
    arr_stale = 1'b0;
    arr_e     = '0;
    if (arr_mul) begin
      arr_e.result   = mq[0].res;
      arr_e.trans_id = mq[0].id;
    end else if (arr_div) begin
      arr_e.result   = div_res;
      arr_e.trans_id = div_id;
    end
    pop = (exp_q.size() != 0) && rdy;

    flush_i       = fl;
    out_ready_i   = rdy;
    issue_mul_i   = imul;
    issue_div_i   = idiv;
    in_valid_i    = arr_mul || arr_div;
    in_result_i   = arr_e.result;
    in_trans_id_i = arr_e.trans_id;

    @(posedge clk_i);
    #1;

    if (arr_mul) begin
      arr_stale = mq[0].stale;
      void'(mq.pop_front());
    end
    if (fl) begin
      exp_q.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      div_active = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if ((arr_mul && !arr_stale) || arr_div) exp_q.push_back(arr_e);
      if (arr_div) div_active = 1'b0;
      else if (div_active && div_cnt > 0) div_cnt--;
    end
    if (imul) mq.push_back('{cyc + MULT_LAT, 1'b0, res, id});
    if (idiv) begin
      div_active = 1'b1;
      div_cnt    = int'($urandom_range(1, 5));
      div_res    = res;
      div_id     = id;
    end
    cyc++;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    div_active    = 1'b0;
    div_cnt       = 0;
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    issue_mul_i   = 1'b0;
    issue_div_i   = 1'b0;
    in_valid_i    = 1'b0;
    in_result_i   = '0;
    in_trans_id_i = '0;
    out_ready_i   = 1'b0;

    #1;
    checkOutput("reset_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("reset_issue_ready", 64'(issue_ready_o), 64'd1);
    checkOutput("reset_out_result", out_result_o, 64'd0);
    checkOutput("reset_out_trans_id", 64'(out_trans_id_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single mul: visible one cycle after its arrival.
    applyStimulus(0, 1, 1, 0, 64'hDEAD, 3);
    applyStimulus(0, 1, 0, 0, 64'd0, 0);
    applyStimulus(0, 1, 0, 0, 64'd0, 0);
    checkOutput("single_valid", 64'(out_valid_o), 64'd1);
    checkOutput("single_result", out_result_o, 64'hDEAD);
    checkOutput("single_trans_id", 64'(out_trans_id_o), 64'd3);
    repeat (2) applyStimulus(0, 1, 0, 0, 64'd0, 0);

    // Back-pressure fill until credits run out, then drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, rnd64(), TRANS_ID_BITS'(i));
    checkOutput("bp_ready_low", 64'(issue_ready_o), 64'd0);
    repeat (3) applyStimulus(0, 0, 0, 0, 64'd0, 0);
    checkOutput("bp_full_valid", 64'(out_valid_o), 64'd1);
    repeat (6) applyStimulus(0, 1, 0, 0, 64'd0, 0);
    checkOutput("bp_drained", 64'(out_valid_o), 64'd0);

    // Flush with entries buffered and muls still in the pipe.
    repeat (2) applyStimulus(0, 0, 1, 0, rnd64(), TRANS_ID_BITS'($urandom));
    repeat (2) applyStimulus(0, 0, 0, 0, 64'd0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0, rnd64(), TRANS_ID_BITS'($urandom));
    applyStimulus(1, 1, 0, 0, 64'd0, 0);
    checkOutput("flush_empty", 64'(out_valid_o), 64'd0);
    applyStimulus(0, 1, 1, 0, 64'hF00D, 5);
    repeat (5) applyStimulus(0, 1, 0, 0, 64'd0, 0);

    // Randomized traffic mixing muls, divs, back-pressure and flushes.
    for (int i = 0; i < 1500; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                    op <= 1, op == 2, rnd64(), TRANS_ID_BITS'($urandom));
    end
    repeat (10) applyStimulus(0, 1, 0, 0, 64'd0, 0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, rnd64(), TRANS_ID_BITS'(i));
    repeat (3) applyStimulus(0, 0, 0, 0, 64'd0, 0);
    applyStimulus(0, 1, 0, 0, 64'd0, 0);
    #2;
    rst_ni      = 1'b0;
    out_ready_i = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    exp_q.delete();
    mq.delete();
    div_active = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (6) applyStimulus(0, 1, 0, 0, 64'd0, 0);
    applyStimulus(0, 1, 1, 0, 64'hBEEF, 6);
    repeat (4) applyStimulus(0, 1, 0, 0, 64'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
